noc_packet_encoder: RTL and testbench
=====================================

Name: noc_packet_encoder

Overview:
- Transmit-side counterpart of the tile's NoC header decoder: builds NoC packets for the 32-bit AXI-stream NoC output of a tile.
- Accepts a packet command (destination, type, length) plus a payload word stream, emits one header flit followed by `len` payload flits, and asserts TLAST on the final flit.
- Sits between tile logic and the NoC output buffer on the clk_line domain.
- Keeps a packet counter and a sticky length-mismatch error flag for software visibility.

Parameters:
- XY_SZ, 4, bits per X or Y coordinate; tile ID and destination are XY_SZ*2 bits (fixed at 8 by the header format).
- OFFSET_SZ, 12, payload length field width in words; max packet payload 2^OFFSET_SZ-1.
- CNT_SZ, 16, width of the packet counter.

Ports:
- clk_line  in  1  single clock.
- clk_line_rst_low  in  1  reset, asynchronous assert, active-low.
- HsrcId  in  XY_SZ*2  this tile's ID; inserted as header source field.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_dst  in  XY_SZ*2  destination tile ID.
- cmd_type  in  4  packet type code.
- cmd_len  in  OFFSET_SZ  payload length in words (0 allowed).
- pay_TVALID  in  1  payload word valid.
- pay_TDATA  in  32  payload word.
- pay_TLAST  in  1  producer's end-of-payload marker (checked only).
- pay_TREADY  out  1  payload word accepted when valid&ready.
- stream_out_TVALID  out  1  NoC flit valid.
- stream_out_TDATA  out  32  NoC flit.
- stream_out_TKEEP  out  4  always 4'hF while valid.
- stream_out_TLAST  out  1  last flit of packet.
- stream_out_TREADY  in  1  NoC backpressure.
- pkt_count  out  CNT_SZ  packets fully emitted; wraps modulo 2^CNT_SZ.
- err_len  out  1  sticky pay_TLAST/length mismatch.
- err_clr  in  1  synchronous clear of err_len.

Behaviour:
- Header flit: [31:24]=cmd_dst, [23:16]=HsrcId, [15:12]=cmd_type, [11:0]=cmd_len.
- Reset values: stream_out_TVALID=0, TDATA=0, TKEEP=0, TLAST=0, cmd_ready=0 during reset, pay_TREADY=0, pkt_count=0, err_len=0. FSM resets to IDLE.
- Output register: a single flit register drives stream_out_*. It loads when `load_ok = !TVALID || TREADY`. Once TVALID=1, data/TLAST/TKEEP stay stable until TREADY. TKEEP=4'hF whenever TVALID=1.
- FSM states: IDLE, PAYLOAD.
- IDLE:
  - cmd_ready = load_ok; pay_TREADY=0.
  - On a command handshake the header loads into the output register (TVALID=1 the next cycle) and the latched remaining count is set to cmd_len.
  - If cmd_len=0: header TLAST=1 and the FSM stays in IDLE.
  - Otherwise: TLAST=0 and the FSM moves to PAYLOAD.
- PAYLOAD:
  - cmd_ready=0; pay_TREADY = load_ok.
  - Each payload handshake loads pay_TDATA into the output register and decrements the remaining count.
  - The word with remaining==1 loads with TLAST=1, and the FSM returns to IDLE on the same edge.
- Latency: command handshake to header valid = 1 cycle; payload handshake to flit valid = 1 cycle.
- Throughput: with TREADY held high, one flit per cycle, and back-to-back packets have zero idle cycles (next header loads while the previous TLAST flit is accepted).
- Length check: a payload word accepted with pay_TLAST != (remaining==1) sets err_len. Emission still follows cmd_len exactly; pay_TLAST never truncates or extends a packet.
- err_clr: clears err_len in the cycle it is asserted. If a mismatch occurs in the same cycle, the set wins.
- pkt_count increments on each output handshake with TLAST=1.
- Backpressure: while TVALID=1 and TREADY=0, neither cmd_ready nor pay_TREADY is asserted. No flit is dropped or duplicated.
- Reset mid-packet: all state is cleared asynchronously and the partial packet is abandoned. After release the block is in IDLE with TVALID=0.
- HsrcId is sampled at header load only.

Test Plan:
- Header only: HsrcId=0x12, cmd dst=0x34, type=1, len=0, TREADY=1 -> single flit 0x34121000, TLAST=1, TKEEP=F, one cycle after handshake; pkt_count=1.
- 3-word packet: len=3, payload 0xA0,0xA1,0xA2 (TLAST on 0xA2), TREADY=1 -> flits 0x34121003,0xA0,0xA1,0xA2 on consecutive cycles, TLAST only on 0xA2; err_len=0.
- Backpressure: same 3-word packet with TREADY toggling 1,0,0,1,... -> TDATA/TLAST held stable while TREADY=0, identical flit sequence, pay_TREADY=0 in stall cycles.
- Back-to-back: two len=2 packets, commands and payload always valid, TREADY=1 -> 6 flits in 6 consecutive cycles, TLAST on flits 3 and 6; pkt_count=2.
- Length mismatch: len=2 with pay_TLAST on first word -> 3 flits still emitted per len, err_len=1 sticky; err_clr pulse -> err_len=0.
- Reset mid-packet: assert reset after header + 1 payload flit of len=4 -> outputs zero immediately; after release a new len=1 packet is emitted correctly.

Source files
------------

// File: rtl/noc_packet_encoder.sv
// rtl/noc_packet_encoder.sv - NoC packet builder: header flit plus len payload flits on a 32-bit stream
module noc_packet_encoder #(
  parameter int XY_SZ     = 4,
  parameter int OFFSET_SZ = 12,
  parameter int CNT_SZ    = 16
) (
  input  logic                   clk_line,
  input  logic                   clk_line_rst_low,
  input  logic [XY_SZ*2-1:0]     HsrcId,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [XY_SZ*2-1:0]     cmd_dst,
  input  logic [3:0]             cmd_type,
  input  logic [OFFSET_SZ-1:0]   cmd_len,
  input  logic                   pay_TVALID,
  input  logic [31:0]            pay_TDATA,
  input  logic                   pay_TLAST,
  output logic                   pay_TREADY,
  output logic                   stream_out_TVALID,
  output logic [31:0]            stream_out_TDATA,
  output logic [3:0]             stream_out_TKEEP,
  output logic                   stream_out_TLAST,
  input  logic                   stream_out_TREADY,
  output logic [CNT_SZ-1:0]      pkt_count,
  output logic                   err_len,
  input  logic                   err_clr
);

  typedef enum logic {ST_IDLE, ST_PAYLOAD} state_t;

  state_t                r_state;
  logic [OFFSET_SZ-1:0]  r_rem;
  logic                  r_tvalid;
  logic [31:0]           r_tdata;
  logic                  r_tlast;
  logic [CNT_SZ-1:0]     r_pkt_count;
  logic                  r_err_len;

  logic                  w_load_ok;
  logic                  w_cmd_hs;
  logic                  w_pay_hs;
  logic                  w_out_hs;
  logic                  w_last_word;
  logic [31:0]           w_header;

  // The flit register may take new data when empty or when its flit leaves this cycle
  assign w_load_ok   = !r_tvalid || stream_out_TREADY;
  assign w_out_hs    = r_tvalid && stream_out_TREADY;
  assign w_last_word = (r_rem == OFFSET_SZ'(1));
  assign w_header    = {cmd_dst, HsrcId, cmd_type, cmd_len};

  // Ready terms are gated by reset so nothing is accepted while the block is held in reset
  assign cmd_ready  = clk_line_rst_low && (r_state == ST_IDLE) && w_load_ok;
  assign pay_TREADY = clk_line_rst_low && (r_state == ST_PAYLOAD) && w_load_ok;
  assign w_cmd_hs   = cmd_valid && cmd_ready;
  assign w_pay_hs   = pay_TVALID && pay_TREADY;

  assign stream_out_TVALID = r_tvalid;
  assign stream_out_TDATA  = r_tdata;
  assign stream_out_TLAST  = r_tlast;
  assign stream_out_TKEEP  = {4{r_tvalid}};
  assign pkt_count         = r_pkt_count;
  assign err_len           = r_err_len;

  // Packet FSM and output flit register: header on command, then exactly cmd_len payload words
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else begin
      if (w_out_hs) begin
        r_tvalid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hs) begin
            r_tdata  <= w_header;
            r_tlast  <= (cmd_len == '0);
            r_tvalid <= 1'b1;
            r_rem    <= cmd_len;
            if (cmd_len != '0) begin
              r_state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_pay_hs) begin
            r_tdata  <= pay_TDATA;
            r_tlast  <= w_last_word;
            r_tvalid <= 1'b1;
            r_rem    <= r_rem - OFFSET_SZ'(1);
            if (w_last_word) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status: count completed packets, sticky flag when producer TLAST disagrees with cmd_len
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      r_pkt_count <= '0;
      r_err_len   <= 1'b0;
    end else begin
      if (w_out_hs && r_tlast) begin
        r_pkt_count <= r_pkt_count + CNT_SZ'(1);
      end
      if (w_pay_hs && (pay_TLAST != w_last_word)) begin
        r_err_len <= 1'b1;
      end else if (err_clr) begin
        r_err_len <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_packet_encoder.sv
// tb/tb_noc_packet_encoder.sv - self-checking bench for noc_packet_encoder
module tb_noc_packet_encoder;

  logic        clk_line = 1'b0;
  logic        clk_line_rst_low;
  logic [7:0]  HsrcId;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_dst;
  logic [3:0]  cmd_type;
  logic [11:0] cmd_len;
  logic        pay_TVALID;
  logic [31:0] pay_TDATA;
  logic        pay_TLAST;
  logic        pay_TREADY;
  logic        stream_out_TVALID;
  logic [31:0] stream_out_TDATA;
  logic [3:0]  stream_out_TKEEP;
  logic        stream_out_TLAST;
  logic        stream_out_TREADY;
  logic [15:0] pkt_count;
  logic        err_len;
  logic        err_clr;

  noc_packet_encoder dut (
    .clk_line          (clk_line),
    .clk_line_rst_low  (clk_line_rst_low),
    .HsrcId            (HsrcId),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_dst           (cmd_dst),
    .cmd_type          (cmd_type),
    .cmd_len           (cmd_len),
    .pay_TVALID        (pay_TVALID),
    .pay_TDATA         (pay_TDATA),
    .pay_TLAST         (pay_TLAST),
    .pay_TREADY        (pay_TREADY),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .stream_out_TREADY (stream_out_TREADY),
    .pkt_count         (pkt_count),
    .err_len           (err_len),
    .err_clr           (err_clr)
  );

  always #5 clk_line = ~clk_line;

  localparam logic [31:0] H0 = 32'h34121000;
  localparam logic [31:0] H3 = 32'h34121003;
  localparam logic [31:0] A0 = 32'h000000A0;
  localparam logic [31:0] A1 = 32'h000000A1;
  localparam logic [31:0] A2 = 32'h000000A2;

  typedef struct {
    logic        cv;
    logic [11:0] len;
    logic        pv;
    logic [31:0] pd;
    logic        pl;
    logic        tr;
    logic        e_crdy;
    logic        e_prdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ol;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[24];
  int   nvec = 0;
  int   total = 0;
  int   bad = 0;

  // sequence driver tables
  int          ncmd, npay, nexp;
  logic [7:0]  c_dst[8];
  logic [3:0]  c_type[8];
  logic [11:0] c_len[8];
  logic [31:0] p_data[16];
  logic        p_last[16];
  logic [31:0] e_data[16];
  logic        e_last[16];

  task automatic v(input logic cv, input logic [11:0] len, input logic pv, input logic [31:0] pd,
                   input logic pl, input logic tr, input logic crdy, input logic prdy, input logic ov,
                   input logic [31:0] od, input logic ol, input logic [15:0] cnt);
    tbl[nvec] = '{cv, len, pv, pd, pl, tr, crdy, prdy, ov, od, ol, cnt};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_seq(input string name);
    int ci, pi, got, cyc;
    logic hc, hp;
    logic [31:0] g_d[16];
    logic        g_l[16];
    int          g_c[16];
    ci = 0; pi = 0; got = 0; cyc = 0;
    while (got < nexp && cyc < 100) begin
      @(negedge clk_line);
      stream_out_TREADY = 1'b1;
      cmd_valid = (ci < ncmd);
      if (ci < ncmd) begin
        cmd_dst = c_dst[ci]; cmd_type = c_type[ci]; cmd_len = c_len[ci];
      end
      pay_TVALID = (pi < npay);
      if (pi < npay) begin
        pay_TDATA = p_data[pi]; pay_TLAST = p_last[pi];
      end
      #1;
      if (stream_out_TVALID && stream_out_TREADY) begin
        g_d[got] = stream_out_TDATA;
        g_l[got] = stream_out_TLAST;
        g_c[got] = cyc;
        got++;
      end
      hc = cmd_valid && cmd_ready;
      hp = pay_TVALID && pay_TREADY;
      @(posedge clk_line);
      if (hc) ci++;
      if (hp) pi++;
      cyc++;
    end
    @(negedge clk_line);
    cmd_valid = 1'b0;
    pay_TVALID = 1'b0;
    pay_TLAST = 1'b0;
    chk({name, " flit count"}, 32'(got), 32'(nexp));
    for (int i = 0; i < got; i++) begin
      chk($sformatf("%s flit%0d data", name, i), g_d[i], e_data[i]);
      chk($sformatf("%s flit%0d last", name, i), 32'(g_l[i]), 32'(e_last[i]));
      chk($sformatf("%s flit%0d cycle", name, i), 32'(g_c[i]), 32'(g_c[0] + i));
    end
  endtask

  initial begin
    clk_line_rst_low = 1'b0;
    HsrcId = 8'h12;
    cmd_valid = 1'b0; cmd_dst = 8'h34; cmd_type = 4'h1; cmd_len = 12'd0;
    pay_TVALID = 1'b0; pay_TDATA = 32'h0; pay_TLAST = 1'b0;
    stream_out_TREADY = 1'b1;
    err_clr = 1'b0;

    // reset state (TREADY high, so cmd_ready must still be held low by reset)
    @(negedge clk_line);
    #1;
    chk("rst cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst pay_TREADY", 32'(pay_TREADY), 32'h0);
    chk("rst TVALID", 32'(stream_out_TVALID), 32'h0);
    chk("rst TDATA", stream_out_TDATA, 32'h0);
    chk("rst TKEEP", 32'(stream_out_TKEEP), 32'h0);
    chk("rst TLAST", 32'(stream_out_TLAST), 32'h0);
    chk("rst pkt_count", 32'(pkt_count), 32'h0);
    chk("rst err_len", 32'(err_len), 32'h0);
    @(negedge clk_line);
    clk_line_rst_low = 1'b1;

    // cycle table: header only, 3-word packet, then 3-word packet under backpressure
    v(1'b1, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'd0);
    v(1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, H0,    1'b1, 16'd0);
    v(1'b1, 12'd3, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'd1);
    v(1'b0, 12'd0, 1'b1, A0,    1'b0, 1'b1,  1'b0, 1'b1, 1'b1, H3,    1'b0, 16'd1);
    v(1'b0, 12'd0, 1'b1, A1,    1'b0, 1'b1,  1'b0, 1'b1, 1'b1, A0,    1'b0, 16'd1);
    v(1'b0, 12'd0, 1'b1, A2,    1'b1, 1'b1,  1'b0, 1'b1, 1'b1, A1,    1'b0, 16'd1);
    v(1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, A2,    1'b1, 16'd1);
    v(1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'd2);
    v(1'b1, 12'd3, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A0,    1'b0, 1'b0,  1'b0, 1'b0, 1'b1, H3,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A0,    1'b0, 1'b0,  1'b0, 1'b0, 1'b1, H3,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A0,    1'b0, 1'b1,  1'b0, 1'b1, 1'b1, H3,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A1,    1'b0, 1'b0,  1'b0, 1'b0, 1'b1, A0,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A1,    1'b0, 1'b0,  1'b0, 1'b0, 1'b1, A0,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A1,    1'b0, 1'b1,  1'b0, 1'b1, 1'b1, A0,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A2,    1'b1, 1'b0,  1'b0, 1'b0, 1'b1, A1,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b1, A2,    1'b1, 1'b1,  1'b0, 1'b1, 1'b1, A1,    1'b0, 16'd2);
    v(1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, A2,    1'b1, 16'd2);
    v(1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, A2,    1'b1, 16'd2);
    v(1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'd3);

    for (int i = 0; i < nvec; i++) begin
      logic ok;
      @(negedge clk_line);
      cmd_valid = tbl[i].cv; cmd_dst = 8'h34; cmd_type = 4'h1; cmd_len = tbl[i].len;
      pay_TVALID = tbl[i].pv; pay_TDATA = tbl[i].pd; pay_TLAST = tbl[i].pl;
      stream_out_TREADY = tbl[i].tr;
      #1;
      ok = (cmd_ready === tbl[i].e_crdy) && (pay_TREADY === tbl[i].e_prdy) &&
           (stream_out_TVALID === tbl[i].e_ov) && (pkt_count === tbl[i].e_cnt) &&
           (stream_out_TKEEP === (tbl[i].e_ov ? 4'hF : 4'h0)) &&
           (!tbl[i].e_ov || ((stream_out_TDATA === tbl[i].e_od) && (stream_out_TLAST === tbl[i].e_ol)));
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL vec%0d: got crdy=%b prdy=%b v=%b d=%h l=%b k=%h cnt=%0d want crdy=%b prdy=%b v=%b d=%h l=%b cnt=%0d",
                 i, cmd_ready, pay_TREADY, stream_out_TVALID, stream_out_TDATA, stream_out_TLAST,
                 stream_out_TKEEP, pkt_count, tbl[i].e_crdy, tbl[i].e_prdy, tbl[i].e_ov,
                 tbl[i].e_od, tbl[i].e_ol, tbl[i].e_cnt);
      end
    end
    @(negedge clk_line);
    cmd_valid = 1'b0; pay_TVALID = 1'b0; pay_TLAST = 1'b0; stream_out_TREADY = 1'b1;
    #1;
    chk("table err_len", 32'(err_len), 32'h0);

    // back-to-back: two len=2 packets with zero idle cycles
    ncmd = 2;
    c_dst[0] = 8'h34; c_type[0] = 4'h1; c_len[0] = 12'd2;
    c_dst[1] = 8'h56; c_type[1] = 4'h2; c_len[1] = 12'd2;
    npay = 4;
    p_data[0] = 32'hB0; p_last[0] = 1'b0;
    p_data[1] = 32'hB1; p_last[1] = 1'b1;
    p_data[2] = 32'hB2; p_last[2] = 1'b0;
    p_data[3] = 32'hB3; p_last[3] = 1'b1;
    nexp = 6;
    e_data[0] = 32'h34121002; e_last[0] = 1'b0;
    e_data[1] = 32'hB0;       e_last[1] = 1'b0;
    e_data[2] = 32'hB1;       e_last[2] = 1'b1;
    e_data[3] = 32'h56122002; e_last[3] = 1'b0;
    e_data[4] = 32'hB2;       e_last[4] = 1'b0;
    e_data[5] = 32'hB3;       e_last[5] = 1'b1;
    run_seq("b2b");
    #1;
    chk("b2b pkt_count", 32'(pkt_count), 32'd5);
    chk("b2b err_len", 32'(err_len), 32'h0);

    // length mismatch: producer TLAST on first of two words
    ncmd = 1;
    c_dst[0] = 8'h34; c_type[0] = 4'h1; c_len[0] = 12'd2;
    npay = 2;
    p_data[0] = 32'hC0; p_last[0] = 1'b1;
    p_data[1] = 32'hC1; p_last[1] = 1'b1;
    nexp = 3;
    e_data[0] = 32'h34121002; e_last[0] = 1'b0;
    e_data[1] = 32'hC0;       e_last[1] = 1'b0;
    e_data[2] = 32'hC1;       e_last[2] = 1'b1;
    run_seq("mismatch");
    #1;
    chk("mismatch err_len set", 32'(err_len), 32'h1);
    chk("mismatch pkt_count", 32'(pkt_count), 32'd6);
    repeat (2) @(negedge clk_line);
    #1;
    chk("mismatch err_len sticky", 32'(err_len), 32'h1);
    @(negedge clk_line);
    err_clr = 1'b1;
    @(negedge clk_line);
    err_clr = 1'b0;
    #1;
    chk("err_clr clears", 32'(err_len), 32'h0);

    // reset mid-packet: header + first payload word of a len=4 packet, then reset
    @(negedge clk_line);
    cmd_valid = 1'b1; cmd_dst = 8'h34; cmd_type = 4'h1; cmd_len = 12'd4;
    stream_out_TREADY = 1'b1;
    @(negedge clk_line);
    cmd_valid = 1'b0;
    pay_TVALID = 1'b1; pay_TDATA = 32'hD0; pay_TLAST = 1'b0;
    @(negedge clk_line);
    pay_TVALID = 1'b0;
    stream_out_TREADY = 1'b0;
    #1;
    chk("midrst pre TDATA", stream_out_TDATA, 32'hD0);
    #2;
    clk_line_rst_low = 1'b0;
    #1;
    chk("midrst TVALID", 32'(stream_out_TVALID), 32'h0);
    chk("midrst TDATA", stream_out_TDATA, 32'h0);
    chk("midrst TKEEP", 32'(stream_out_TKEEP), 32'h0);
    chk("midrst pkt_count", 32'(pkt_count), 32'h0);
    @(negedge clk_line);
    clk_line_rst_low = 1'b1;
    stream_out_TREADY = 1'b1;
    ncmd = 1;
    c_dst[0] = 8'h34; c_type[0] = 4'h1; c_len[0] = 12'd1;
    npay = 1;
    p_data[0] = 32'hE0; p_last[0] = 1'b1;
    nexp = 2;
    e_data[0] = 32'h34121001; e_last[0] = 1'b0;
    e_data[1] = 32'hE0;       e_last[1] = 1'b1;
    run_seq("postrst");
    #1;
    chk("postrst pkt_count", 32'(pkt_count), 32'd1);
    chk("postrst err_len", 32'(err_len), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
